axis_pkt_snooper: RTL and testbench

Passive tap on an AXI-Stream link that copies whole packets into packet memory. It sits directly upstream of the snooper width adapter and drives its addr / wr_data / wr_en / byte_inc / done inputs. It never asserts backpressure: TREADY is observed, not driven. A packet is captured only if packet memory signals readiness at the packet's first beat; otherwise the packet is skipped in full.

---
 rtl/axis_pkt_snooper.sv | 136 +++++++++++++
 tb/tb_axis_pkt_snooper.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_snooper.sv
// Passive AXI-Stream tap that copies whole packets into packet memory, one write per captured beat.
// Optional feature macro: AXIS_SNOOPER_TKEEP_EN adds sn_TKEEP and reports partial last beats.
module axis_pkt_snooper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int INC_WIDTH  = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   sn_TDATA,
`ifdef AXIS_SNOOPER_TKEEP_EN
  input  logic [DATA_WIDTH/8-1:0] sn_TKEEP,
`endif
  input  logic                    sn_TVALID,
  input  logic                    sn_TREADY,
  input  logic                    sn_TLAST,
  input  logic                    rdy_for_sn,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_en,
  output logic [INC_WIDTH-1:0]    byte_inc,
  output logic                    done
);

  localparam logic [INC_WIDTH-1:0]  FULL_INC  = INC_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DROP,
    COOL
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wr_en_q;
  logic [INC_WIDTH-1:0]    inc_q;
  logic                    done_q;

  logic                    beat;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [INC_WIDTH-1:0]    inc_d;

  assign beat   = sn_TVALID & sn_TREADY;
  assign addr_d = addr_q + 1'b1;

`ifdef AXIS_SNOOPER_TKEEP_EN
  logic [INC_WIDTH-1:0] keep_cnt;

  // TKEEP is contiguous from bit 0, so its popcount is the byte count; the sum wraps like byte_inc.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every output a default first,
    // so the accumulator is well defined on every pass and no latch is inferred.
    keep_cnt = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      keep_cnt = keep_cnt + INC_WIDTH'(sn_TKEEP[i]);
    end
  end

  assign inc_d = sn_TLAST ? keep_cnt : FULL_INC;
`else
  assign inc_d = FULL_INC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Position in the stream is unknown after reset: discard up to the next TLAST.
      state_q <= DROP;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      inc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the strobes default low here
      // and are raised only on the cycle a write is issued.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (beat) begin
            if (rdy_for_sn) begin
              addr_q  <= '0;
              data_q  <= sn_TDATA;
              inc_q   <= inc_d;
              wr_en_q <= 1'b1;
              if (sn_TLAST) begin
                done_q  <= 1'b1;
                state_q <= COOL;
              end else begin
                state_q <= CAPTURE;
              end
            end else if (!sn_TLAST) begin
              state_q <= DROP;
            end
          end
        end
        CAPTURE: begin
          if (beat) begin
            addr_q  <= addr_d;
            data_q  <= sn_TDATA;
            inc_q   <= inc_d;
            wr_en_q <= 1'b1;
            if (sn_TLAST) begin
              done_q  <= 1'b1;
              state_q <= COOL;
            end else if (addr_d == LAST_ADDR) begin
              // Buffer full: close it here and discard the rest of the packet.
              done_q  <= 1'b1;
              state_q <= DROP;
            end
          end
        end
        DROP: begin
          if (beat && sn_TLAST) begin
            state_q <= IDLE;
          end
        end
        COOL: begin
          // Memory needs this cycle to drop rdy_for_sn; a packet starting now is skipped.
          state_q <= (beat && !sn_TLAST) ? DROP : IDLE;
        end
        default: state_q <= DROP;
      endcase
    end
  end

  assign addr     = addr_q;
  assign wr_data  = data_q;
  assign wr_en    = wr_en_q;
  assign byte_inc = inc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_axis_pkt_snooper.sv
// Self-checking bench for axis_pkt_snooper: directed scenarios plus randomized packets,
// checked against a packet-level reference model. Works with or without AXIS_SNOOPER_TKEEP_EN.
module tb_axis_pkt_snooper;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int IW    = $clog2(DW / 8);
  localparam int BPW   = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef AXIS_SNOOPER_TKEEP_EN
  localparam bit KEEP_EN = 1'b1;
`else
  localparam bit KEEP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sn_TDATA = '0;
`ifdef AXIS_SNOOPER_TKEEP_EN
  logic [BPW-1:0] sn_TKEEP = '0;
`endif
  logic          sn_TVALID = 1'b0;
  logic          sn_TREADY = 1'b0;
  logic          sn_TLAST = 1'b0;
  logic          rdy_for_sn = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [IW-1:0] byte_inc;
  logic          done;

  axis_pkt_snooper #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sn_TDATA  (sn_TDATA),
`ifdef AXIS_SNOOPER_TKEEP_EN
    .sn_TKEEP  (sn_TKEEP),
`endif
    .sn_TVALID (sn_TVALID),
    .sn_TREADY (sn_TREADY),
    .sn_TLAST  (sn_TLAST),
    .rdy_for_sn(rdy_for_sn),
    .addr      (addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .byte_inc  (byte_inc),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    int            addr;
    logic [DW-1:0] data;
    int            inc;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  int   wr_seen = 0;
  int   done_seen = 0;

  // Packet-level reference model state.
  bit m_start = 1'b0;
  bit m_cap = 1'b0;
  int m_idx = 0;
  int m_cool_edge = -10;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Write monitor: every cycle either a predicted write appears, or nothing is written.
  always @(negedge clk) begin
    exp_t h;
    if (!rst && wr_en === 1'b1) wr_seen++;
    if (!rst && done === 1'b1) done_seen++;
    if (rst) begin
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0 || addr !== '0 || wr_data !== '0 || byte_inc !== '0) begin
        errors++;
        $display("FAIL in_reset: en=%0b done=%0b addr=%0d data=%h inc=%0d, want all zero",
                 wr_en, done, addr, wr_data, byte_inc);
      end
    end else if (exp_q.size() != 0 && exp_q[0].due == edge_cnt) begin
      h = exp_q.pop_front();
      checks++;
      if (wr_en !== 1'b1 || addr !== h.addr[AW-1:0] || wr_data !== h.data ||
          byte_inc !== h.inc[IW-1:0] || done !== h.done) begin
        errors++;
        $display("FAIL write edge %0d: got en=%0b addr=%0d data=%h inc=%0d done=%0b, want en=1 addr=%0d data=%h inc=%0d done=%0b",
                 edge_cnt, wr_en, addr, wr_data, byte_inc, done, h.addr, h.data, h.inc, h.done);
      end
    end else begin
      checks++;
      if (wr_en !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL unexpected_write edge %0d: got en=%0b done=%0b addr=%0d, want en=0 done=0",
                 edge_cnt, wr_en, done, addr);
      end
    end
  end

  // A beat at edge e: capture is decided at the first beat of a packet, a packet starting the
  // edge right after a done-with-TLAST is skipped, and at most DEPTH beats are stored.
  task automatic model_beat(input int e, input logic [DW-1:0] d, input logic l, input int nk,
                            input logic r);
    exp_t x;
    if (m_start) begin
      m_cap = r && (e != m_cool_edge + 1);
      m_idx = 0;
    end
    if (m_cap && m_idx < DEPTH) begin
      x.due  = e;
      x.addr = m_idx;
      x.data = d;
      x.inc  = ((l && KEEP_EN) ? nk : BPW) % (1 << IW);
      x.done = l || (m_idx == DEPTH - 1);
      exp_q.push_back(x);
      if (l) m_cool_edge = e;
    end
    m_idx++;
    m_start = l;
  endtask

  task automatic drive(input logic v, input logic rd, input logic [DW-1:0] d, input logic l,
                       input int nk, input logic r);
    @(negedge clk);
    sn_TVALID  = v;
    sn_TREADY  = rd;
    sn_TDATA   = d;
    sn_TLAST   = l;
    rdy_for_sn = r;
`ifdef AXIS_SNOOPER_TKEEP_EN
    sn_TKEEP = '0;
    for (int i = 0; i < nk; i++) sn_TKEEP[i] = 1'b1;
`endif
    if (v && rd && !rst) model_beat(edge_cnt + 1, d, l, nk, r);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l, input int nk, input logic r);
    drive(1'b1, 1'b1, d, l, nk, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(1)), $urandom(), 1'b0, BPW, 1'b1);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, $urandom(), 1'($urandom_range(1)), BPW, 1'b1);
  endtask

  task automatic send_pkt(input int len, input logic r_first, input int nk_last, input int gap_max);
    for (int i = 0; i < len; i++) begin
      if (i > 0) begin
        if ($urandom_range(1) == 1) stall($urandom_range(gap_max));
        else idle($urandom_range(gap_max));
      end
      beat($urandom(), i == len - 1, (i == len - 1) ? nk_last : BPW,
           (i == 0) ? r_first : 1'($urandom_range(1)));
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    sn_TVALID = 1'b0;
    #1 rst = 1'b1;
    exp_q.delete();
    m_start = 1'b0;
    m_cap   = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || addr !== '0 || wr_data !== '0 || byte_inc !== '0) begin
      errors++;
      $display("FAIL async_reset: en=%0b done=%0b addr=%0d data=%h inc=%0d, want all zero",
               wr_en, done, addr, wr_data, byte_inc);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    sn_TVALID = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic expect_count(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (wr_en !== 1'b0 || done !== 1'b0 || addr !== '0 || wr_data !== '0 || byte_inc !== '0) begin
      errors++;
      $display("FAIL reset_state: en=%0b done=%0b addr=%0d data=%h inc=%0d, want all zero",
               wr_en, done, addr, wr_data, byte_inc);
    end
  endtask

  task automatic test_reset_sync();
    int w0 = wr_seen;
    beat(32'hA0A0A0A0, 1'b0, BPW, 1'b1);
    release_reset();
    beat(32'hA1A1A1A1, 1'b0, BPW, 1'b1);
    beat(32'hA2A2A2A2, 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("sync_first_pkt_writes", wr_seen - w0, 0);
    beat(32'hB0B0B0B0, 1'b0, BPW, 1'b1);
    beat(32'hB1B1B1B1, 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("sync_second_pkt_writes", wr_seen - w0, 2);
    expect_count("sync_last_addr", int'(addr), 1);
  endtask

  task automatic test_basic();
    int w0 = wr_seen;
    beat(32'h11111111, 1'b0, BPW, 1'b1);
    beat(32'h22222222, 1'b0, BPW, 1'b1);
    beat(32'h33333333, 1'b0, BPW, 1'b1);
    beat(32'h44444444, 1'b1, 3, 1'b1);
    @(negedge clk);
    sn_TVALID = 1'b0;
    expect_count("basic_last_inc", int'(byte_inc), KEEP_EN ? 3 : 0);
    idle(2);
    expect_count("basic_writes", wr_seen - w0, 4);
    expect_count("basic_hold_addr", int'(addr), 3);
    checks++;
    if (wr_data !== 32'h44444444) begin
      errors++;
      $display("FAIL basic_hold_data: got %h, want 44444444", wr_data);
    end
  endtask

  task automatic test_not_ready();
    int w0 = wr_seen;
    beat($urandom(), 1'b0, BPW, 1'b0);
    for (int i = 1; i < 5; i++) beat($urandom(), i == 4, BPW, 1'b1);
    idle(2);
    expect_count("not_ready_writes", wr_seen - w0, 0);
    beat($urandom(), 1'b0, BPW, 1'b1);
    beat($urandom(), 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("after_not_ready_writes", wr_seen - w0, 2);
    expect_count("after_not_ready_addr", int'(addr), 1);
  endtask

  task automatic test_stalls();
    int w0 = wr_seen;
    beat(32'hC0000000, 1'b0, BPW, 1'b1);
    stall(2);
    beat(32'hC1111111, 1'b0, BPW, 1'b0);
    stall(2);
    idle(1);
    beat(32'hC2222222, 1'b1, BPW, 1'b0);
    idle(2);
    expect_count("stall_writes", wr_seen - w0, 3);
    expect_count("stall_addr", int'(addr), 2);
    checks++;
    if (wr_data !== 32'hC2222222) begin
      errors++;
      $display("FAIL stall_data: got %h, want c2222222", wr_data);
    end
  endtask

  task automatic test_overflow();
    int w0 = wr_seen;
    int d0 = done_seen;
    for (int i = 0; i < 6; i++) beat($urandom(), i == 5, BPW, 1'b1);
    idle(2);
    expect_count("overflow_writes", wr_seen - w0, 4);
    expect_count("overflow_dones", done_seen - d0, 1);
    expect_count("overflow_addr", int'(addr), 3);
    beat($urandom(), 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("after_overflow_addr", int'(addr), 0);
  endtask

  task automatic test_back_to_back();
    int w0 = wr_seen;
    idle(2);
    beat(32'hD1D1D1D1, 1'b1, BPW, 1'b1);
    beat(32'hD2D2D2D2, 1'b1, BPW, 1'b1);
    beat(32'hD3D3D3D3, 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("b2b_writes", wr_seen - w0, 2);
    checks++;
    if (wr_data !== 32'hD3D3D3D3) begin
      errors++;
      $display("FAIL b2b_data: got %h, want d3d3d3d3", wr_data);
    end
  endtask

  task automatic test_reset_mid_capture();
    int w0 = wr_seen;
    int d0 = done_seen;
    idle(2);
    beat($urandom(), 1'b0, BPW, 1'b1);
    beat($urandom(), 1'b0, BPW, 1'b1);
    assert_reset();
    release_reset();
    beat($urandom(), 1'b0, BPW, 1'b1);
    beat($urandom(), 1'b1, BPW, 1'b1);
    beat($urandom(), 1'b0, BPW, 1'b1);
    beat($urandom(), 1'b1, BPW, 1'b1);
    idle(2);
    expect_count("mid_reset_writes", wr_seen - w0, 4);
    expect_count("mid_reset_dones", done_seen - d0, 1);
  endtask

  task automatic test_random();
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(7, 1), 1'($urandom_range(3) != 0), $urandom_range(BPW, 1), 2);
      idle($urandom_range(2));
    end
    idle(3);
    expect_count("random_pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_reset_sync();
    test_basic();
    test_not_ready();
    test_stalls();
    test_overflow();
    test_back_to_back();
    test_reset_mid_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
